// File: rtl/tpu_ctrl_pkg.sv
// Shared types and constants for the TPU control-plane sequencer.
// Covers FSM states, command codes, register offsets and STATUS bit positions.
package tpu_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StTpuRst = 3'd1,
        StFill   = 3'd2,
        StDrain  = 3'd3,
        StMult   = 3'd4,
        StErr    = 3'd5
    } state_e;

    localparam logic [3:0] CmdReset    = 4'b1111;
    localparam logic [3:0] CmdFillFifo = 4'b0001;
    localparam logic [3:0] CmdFillArr  = 4'b0010;
    localparam logic [3:0] CmdMultiply = 4'b0011;

    localparam logic [1:0] SpaceCtrl = 2'b00;

    localparam logic [7:0] RegCmd     = 8'h00;
    localparam logic [7:0] RegInBase  = 8'h01;
    localparam logic [7:0] RegOutBase = 8'h02;
    localparam logic [7:0] RegWtBase  = 8'h03;
    localparam logic [7:0] RegStatus  = 8'h04;

    localparam int unsigned StsBusy        = 3;
    localparam int unsigned StsFifoLoaded  = 4;
    localparam int unsigned StsArrLoaded   = 5;
    localparam int unsigned StsMultDone    = 6;
    localparam int unsigned StsTimeoutErr  = 7;
    localparam int unsigned StsCmdRejected = 8;
    localparam int unsigned StsWidth       = 9;

endpackage

// File: rtl/tpu_ctrl_sequencer_if.sv
// Avalon control-space bus between the slave decode and the sequencer.
interface tpu_ctrl_sequencer_if #(
    parameter int unsigned DATA_WIDTH = 64
);
    logic [9:0]            slave_address;
    logic                  slave_read;
    logic                  slave_write;
    logic [DATA_WIDTH-1:0] slave_writedata;
    logic [DATA_WIDTH-1:0] ctrl_readdata;
    logic                  ctrl_readdata_valid;

    modport master (
        output slave_address, slave_read, slave_write, slave_writedata,
        input  ctrl_readdata, ctrl_readdata_valid
    );

    modport slave (
        input  slave_address, slave_read, slave_write, slave_writedata,
        output ctrl_readdata, ctrl_readdata_valid
    );
endinterface

// File: rtl/tpu_ctrl_watchdog.sv
// Cycle counter for the operation watchdog; expired fires on the last allowed
// cycle of an enabled run so the FSM can leave on the following edge.
module tpu_ctrl_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = enable && (cnt == CntLast);
endmodule

// File: rtl/tpu_ctrl_sequencer.sv
// Control-space register decode, base-address registers and command FSM
// driving the TPU top's control ports.
module tpu_ctrl_sequencer
    import tpu_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned RESET_CYCLES   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    tpu_ctrl_sequencer_if.slave   bus,
    output logic                  tpu_reset,
    output logic                  fill_fifo,
    output logic                  drain_fifo,
    output logic                  active,
    output logic [ADDR_WIDTH-1:0] inputMem_rd_addr_base,
    output logic [ADDR_WIDTH-1:0] outputMem_wr_addr_base,
    output logic [ADDR_WIDTH-1:0] weightMem_rd_addr_base,
    input  logic                  mem_to_fifo_done,
    input  logic                  fifo_to_arr_done,
    input  logic                  output_done,
    output logic                  busy
);
    localparam int unsigned RstCntW = $clog2(RESET_CYCLES + 1);
    localparam logic [RstCntW-1:0] RstLoad = RstCntW'(RESET_CYCLES - 1);

    state_e               state_q, state_d;
    logic [RstCntW-1:0]   rst_cnt_q;
    logic                 fifo_loaded_q, arr_loaded_q, mult_done_q, timeout_err_q, cmd_rejected_q;
    logic [StsWidth-1:0]  status_bits;
    logic [DATA_WIDTH-1:0] rdata;
    logic                 wd_wait, wd_expired;

    logic       ctrl_sel, rd_en, wr_en, cmd_wr, cmd_reset, cmd_op, base_wr;
    logic [7:0] reg_off;
    logic [3:0] cmd;

    assign ctrl_sel  = (bus.slave_address[9:8] == SpaceCtrl);
    assign reg_off   = bus.slave_address[7:0];
    assign rd_en     = bus.slave_read && ctrl_sel;
    assign wr_en     = bus.slave_write && ctrl_sel;
    assign cmd       = bus.slave_writedata[3:0];
    assign cmd_wr    = wr_en && (reg_off == RegCmd);
    assign cmd_reset = cmd_wr && (cmd == CmdReset);
    assign cmd_op    = cmd_wr && (cmd == CmdFillFifo || cmd == CmdFillArr || cmd == CmdMultiply);
    assign base_wr   = wr_en && (reg_off == RegInBase || reg_off == RegOutBase ||
                                 reg_off == RegWtBase);
    assign wd_wait   = (state_q == StFill) || (state_q == StDrain) || (state_q == StMult);

    tpu_ctrl_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (!wd_wait),
        .enable (wd_wait),
        .expired(wd_expired)
    );

    // RESET pre-empts every state; a done arriving with its timeout still wins.
    always_comb begin
        state_d = state_q;
        if (cmd_reset) begin
            state_d = StTpuRst;
        end else begin
            case (state_q)
                StIdle: begin
                    if (cmd_op) begin
                        case (cmd)
                            CmdFillFifo: state_d = StFill;
                            CmdFillArr:  state_d = StDrain;
                            default:     state_d = StMult;
                        endcase
                    end
                end
                StTpuRst: if (rst_cnt_q == '0) state_d = StIdle;
                StFill:   state_d = mem_to_fifo_done ? StIdle : (wd_expired ? StErr : StFill);
                StDrain:  state_d = fifo_to_arr_done ? StIdle : (wd_expired ? StErr : StDrain);
                StMult:   state_d = output_done ? StIdle : (wd_expired ? StErr : StMult);
                StErr:    state_d = StErr;
                default:  state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        status_bits                 = '0;
        status_bits[2:0]            = state_q;
        status_bits[StsBusy]        = busy;
        status_bits[StsFifoLoaded]  = fifo_loaded_q;
        status_bits[StsArrLoaded]   = arr_loaded_q;
        status_bits[StsMultDone]    = mult_done_q;
        status_bits[StsTimeoutErr]  = timeout_err_q;
        status_bits[StsCmdRejected] = cmd_rejected_q;
        case (reg_off)
            RegInBase:  rdata = DATA_WIDTH'(inputMem_rd_addr_base);
            RegOutBase: rdata = DATA_WIDTH'(outputMem_wr_addr_base);
            RegWtBase:  rdata = DATA_WIDTH'(weightMem_rd_addr_base);
            RegStatus:  rdata = DATA_WIDTH'(status_bits);
            default:    rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q                 <= StIdle;
            rst_cnt_q               <= '0;
            tpu_reset               <= 1'b0;
            fill_fifo               <= 1'b0;
            drain_fifo              <= 1'b0;
            active                  <= 1'b0;
            busy                    <= 1'b0;
            fifo_loaded_q           <= 1'b0;
            arr_loaded_q            <= 1'b0;
            mult_done_q             <= 1'b0;
            timeout_err_q           <= 1'b0;
            cmd_rejected_q          <= 1'b0;
            inputMem_rd_addr_base   <= '0;
            outputMem_wr_addr_base  <= '0;
            weightMem_rd_addr_base  <= '0;
            bus.ctrl_readdata       <= '0;
            bus.ctrl_readdata_valid <= 1'b0;
        end else begin
            state_q    <= state_d;
            tpu_reset  <= (state_d == StTpuRst);
            fill_fifo  <= (state_d == StFill);
            drain_fifo <= (state_d == StDrain);
            active     <= (state_d == StMult);
            busy       <= (state_d != StIdle);

            if (cmd_reset) begin
                rst_cnt_q <= RstLoad;
            end else if (state_q == StTpuRst && rst_cnt_q != '0) begin
                rst_cnt_q <= rst_cnt_q - 1'b1;
            end

            if (cmd_reset) begin
                fifo_loaded_q  <= 1'b0;
                arr_loaded_q   <= 1'b0;
                mult_done_q    <= 1'b0;
                timeout_err_q  <= 1'b0;
                cmd_rejected_q <= 1'b0;
            end else begin
                if (cmd_op) begin
                    if (state_q == StIdle) begin
                        cmd_rejected_q <= 1'b0;
                        case (cmd)
                            CmdFillFifo: fifo_loaded_q <= 1'b0;
                            CmdFillArr:  arr_loaded_q  <= 1'b0;
                            default:     mult_done_q   <= 1'b0;
                        endcase
                    end else begin
                        cmd_rejected_q <= 1'b1;
                    end
                end
                if (base_wr) begin
                    if (busy) begin
                        cmd_rejected_q <= 1'b1;
                    end else begin
                        case (reg_off)
                            RegInBase:  inputMem_rd_addr_base <=
                                            bus.slave_writedata[ADDR_WIDTH-1:0];
                            RegOutBase: outputMem_wr_addr_base <=
                                            bus.slave_writedata[ADDR_WIDTH-1:0];
                            default:    weightMem_rd_addr_base <=
                                            bus.slave_writedata[ADDR_WIDTH-1:0];
                        endcase
                    end
                end
                if (state_q == StFill && mem_to_fifo_done) fifo_loaded_q <= 1'b1;
                if (state_q == StDrain && fifo_to_arr_done) arr_loaded_q <= 1'b1;
                if (state_q == StMult && output_done) mult_done_q <= 1'b1;
                if (wd_wait && state_d == StErr) timeout_err_q <= 1'b1;
            end

            // STATUS read reflects pre-write state since rdata uses current flops.
            bus.ctrl_readdata_valid <= rd_en;
            if (rd_en) bus.ctrl_readdata <= rdata;
        end
    end
endmodule

// File: tb/tb_tpu_ctrl_sequencer.sv
// Directed bench for tpu_ctrl_sequencer with a short watchdog for the timeout path.
module tb_tpu_ctrl_sequencer;
    localparam int unsigned DW = 64;
    localparam int unsigned AW = 8;

    logic clk = 1'b0;
    logic reset;
    logic tpu_reset, fill_fifo, drain_fifo, active, busy;
    logic [AW-1:0] in_base, out_base, wt_base;
    logic mem_to_fifo_done, fifo_to_arr_done, output_done;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    tpu_ctrl_sequencer_if #(.DATA_WIDTH(DW)) bus ();

    tpu_ctrl_sequencer #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .RESET_CYCLES  (4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .bus                   (bus),
        .tpu_reset             (tpu_reset),
        .fill_fifo             (fill_fifo),
        .drain_fifo            (drain_fifo),
        .active                (active),
        .inputMem_rd_addr_base (in_base),
        .outputMem_wr_addr_base(out_base),
        .weightMem_rd_addr_base(wt_base),
        .mem_to_fifo_done      (mem_to_fifo_done),
        .fifo_to_arr_done      (fifo_to_arr_done),
        .output_done           (output_done),
        .busy                  (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [9:0] a, input logic [DW-1:0] d);
        bus.slave_address   = a;
        bus.slave_writedata = d;
        bus.slave_write     = 1'b1;
        tick();
        bus.slave_write     = 1'b0;
    endtask

    task automatic rd(input logic [9:0] a, output logic [DW-1:0] d, output logic v);
        bus.slave_address = a;
        bus.slave_read    = 1'b1;
        tick();
        bus.slave_read    = 1'b0;
        d = bus.ctrl_readdata;
        v = bus.ctrl_readdata_valid;
    endtask

    task automatic test_reset();
        logic [DW-1:0] d;
        logic v;
        reset = 1'b1;
        bus.slave_address = '0; bus.slave_read = 1'b0; bus.slave_write = 1'b0;
        bus.slave_writedata = '0;
        mem_to_fifo_done = 1'b0; fifo_to_arr_done = 1'b0; output_done = 1'b0;
        tick(); tick();
        reset = 1'b0;
        vectors++;
        if ({tpu_reset, fill_fifo, drain_fifo, active, busy} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl got %b want 00000",
                     {tpu_reset, fill_fifo, drain_fifo, active, busy});
        end
        vectors++;
        if ({in_base, out_base, wt_base, bus.ctrl_readdata_valid} !== 25'b0) begin
            miscompares++;
            $display("FAIL reset_base got %h %h %h v=%b want zeros",
                     in_base, out_base, wt_base, bus.ctrl_readdata_valid);
        end
        rd(10'h004, d, v);
        vectors++;
        if (v !== 1'b1) begin miscompares++; $display("FAIL rd_valid got %b want 1", v); end
        vectors++;
        if (d !== 64'h0) begin miscompares++; $display("FAIL reset_status got %h want 0", d); end
        tick();
        vectors++;
        if (bus.ctrl_readdata_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_valid_pulse got %b want 0", bus.ctrl_readdata_valid);
        end
        wr(10'h001, 64'h2A);
        rd(10'h001, d, v);
        vectors++;
        if (d !== 64'h2A) begin miscompares++; $display("FAIL in_base_rd got %h want 2a", d); end
        tick();
        vectors++;
        if (bus.ctrl_readdata !== 64'h2A || in_base !== 8'h2A) begin
            miscompares++;
            $display("FAIL in_base_hold got %h/%h want 2a/2a", bus.ctrl_readdata, in_base);
        end
    endtask

    task automatic test_fill();
        logic [DW-1:0] d;
        logic v;
        int n = 0;
        wr(10'h000, 64'h1);
        for (int i = 0; i < 10; i++) begin
            if (fill_fifo) n++;
            if (i == 9) mem_to_fifo_done = 1'b1;
            tick();
        end
        mem_to_fifo_done = 1'b0;
        vectors++;
        if (n !== 10) begin miscompares++; $display("FAIL fill_len got %0d want 10", n); end
        vectors++;
        if ({fill_fifo, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL fill_exit got %b want 00", {fill_fifo, busy});
        end
        rd(10'h004, d, v);
        vectors++;
        if (d !== 64'h010) begin miscompares++; $display("FAIL fill_status got %h want 10", d); end
    endtask

    task automatic test_drain_mult();
        logic [DW-1:0] d;
        logic v;
        wr(10'h000, 64'h2);
        vectors++;
        if ({fill_fifo, drain_fifo, active} !== 3'b010) begin
            miscompares++;
            $display("FAIL drain_on got %b want 010", {fill_fifo, drain_fifo, active});
        end
        output_done = 1'b1; mem_to_fifo_done = 1'b1;
        tick();
        output_done = 1'b0; mem_to_fifo_done = 1'b0;
        vectors++;
        if (drain_fifo !== 1'b1) begin
            miscompares++;
            $display("FAIL foreign_done got %b want 1", drain_fifo);
        end
        fifo_to_arr_done = 1'b1;
        tick();
        fifo_to_arr_done = 1'b0;
        wr(10'h000, 64'h3);
        vectors++;
        if ({fill_fifo, drain_fifo, active} !== 3'b001) begin
            miscompares++;
            $display("FAIL mult_on got %b want 001", {fill_fifo, drain_fifo, active});
        end
        tick(); tick();
        output_done = 1'b1;
        tick();
        output_done = 1'b0;
        vectors++;
        if ({active, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL mult_exit got %b want 00", {active, busy});
        end
        rd(10'h004, d, v);
        vectors++;
        if (d !== 64'h070) begin miscompares++; $display("FAIL dm_status got %h want 70", d); end
    endtask

    task automatic test_reject();
        logic [DW-1:0] d;
        logic v;
        wr(10'h002, 64'h33);
        wr(10'h000, 64'h3);
        wr(10'h000, 64'h1);
        vectors++;
        if ({fill_fifo, drain_fifo, active} !== 3'b001) begin
            miscompares++;
            $display("FAIL rej_cmd got %b want 001", {fill_fifo, drain_fifo, active});
        end
        wr(10'h002, 64'h55);
        vectors++;
        if (out_base !== 8'h33) begin miscompares++; $display("FAIL rej_base got %h want 33", out_base); end
        rd(10'h004, d, v);
        vectors++;
        if (d !== 64'h13C) begin miscompares++; $display("FAIL rej_status got %h want 13c", d); end
        output_done = 1'b1;
        tick();
        output_done = 1'b0;
        rd(10'h004, d, v);
        vectors++;
        if (d !== 64'h170) begin miscompares++; $display("FAIL rej_sticky got %h want 170", d); end
    endtask

    task automatic test_timeout();
        logic [DW-1:0] d;
        logic v;
        int n = 0;
        wr(10'h000, 64'h3);
        while (active && n < 40) begin n++; tick(); end
        vectors++;
        if (n !== 16) begin miscompares++; $display("FAIL wd_len got %0d want 16", n); end
        vectors++;
        if ({tpu_reset, fill_fifo, drain_fifo, active, busy} !== 5'b00001) begin
            miscompares++;
            $display("FAIL err_outs got %b want 00001",
                     {tpu_reset, fill_fifo, drain_fifo, active, busy});
        end
        rd(10'h004, d, v);
        vectors++;
        if (d !== 64'h0BD) begin miscompares++; $display("FAIL err_status got %h want bd", d); end
        wr(10'h000, 64'h1);
        rd(10'h004, d, v);
        vectors++;
        if (d !== 64'h1BD || fill_fifo !== 1'b0) begin
            miscompares++;
            $display("FAIL err_reject got %h fill=%b want 1bd fill=0", d, fill_fifo);
        end
        wr(10'h000, 64'hF);
        n = 0;
        while (tpu_reset && n < 20) begin n++; tick(); end
        vectors++;
        if (n !== 4) begin miscompares++; $display("FAIL rst_len got %0d want 4", n); end
        rd(10'h004, d, v);
        vectors++;
        if (d !== 64'h0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_status got %h busy=%b want 0 busy=0", d, busy);
        end
    endtask

    task automatic test_reset_race();
        logic [DW-1:0] d;
        logic v;
        int n = 0;
        wr(10'h000, 64'h2);
        tick(); tick();
        bus.slave_address = 10'h000; bus.slave_writedata = 64'hF; bus.slave_write = 1'b1;
        fifo_to_arr_done = 1'b1;
        tick();
        bus.slave_write = 1'b0; fifo_to_arr_done = 1'b0;
        vectors++;
        if ({tpu_reset, drain_fifo} !== 2'b10) begin
            miscompares++;
            $display("FAIL race_outs got %b want 10", {tpu_reset, drain_fifo});
        end
        rd(10'h004, d, v);
        vectors++;
        if (d !== 64'h009) begin miscompares++; $display("FAIL race_status got %h want 9", d); end
        while (tpu_reset && n < 20) begin n++; tick(); end
        rd(10'h004, d, v);
        vectors++;
        if (d[5] !== 1'b0 || d !== 64'h0) begin
            miscompares++;
            $display("FAIL race_arr got %h want 0", d);
        end
    endtask

    task automatic test_rw_same();
        logic [DW-1:0] d;
        logic v;
        bus.slave_address = 10'h001; bus.slave_writedata = 64'h77;
        bus.slave_read = 1'b1; bus.slave_write = 1'b1;
        tick();
        bus.slave_read = 1'b0; bus.slave_write = 1'b0;
        vectors++;
        if (bus.ctrl_readdata !== 64'h2A || in_base !== 8'h77) begin
            miscompares++;
            $display("FAIL rw_same got %h/%h want 2a/77", bus.ctrl_readdata, in_base);
        end
        rd(10'h101, d, v);
        vectors++;
        if (v !== 1'b0) begin miscompares++; $display("FAIL other_space got v=%b want 0", v); end
        wr(10'h101, 64'h99);
        vectors++;
        if (in_base !== 8'h77) begin miscompares++; $display("FAIL other_wr got %h want 77", in_base); end
        rd(10'h010, d, v);
        vectors++;
        if (v !== 1'b1 || d !== 64'h0) begin
            miscompares++;
            $display("FAIL unmapped got v=%b d=%h want 1/0", v, d);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got stuck want finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        test_reset();
        test_fill();
        test_drain_mult();
        test_reject();
        test_timeout();
        test_reset_race();
        test_rw_same();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
